// File: rtl/kfx86_pkg.sv
// Shared KFX86 execution-unit definitions: FLAGS layout, ALU opcodes and parity helper.
package kfx86_pkg;

  typedef struct packed {
    logic [3:0] rsv_15_12;
    logic       o;
    logic       d;
    logic       i;
    logic       t;
    logic       s;
    logic       z;
    logic       rsv_5;
    logic       a;
    logic       rsv_3;
    logic       p;
    logic       rsv_1;
    logic       c;
  } flags_t;

  localparam logic [4:0] ALU_OP_ADD = 5'd0;
  localparam logic [4:0] ALU_OP_OR  = 5'd1;
  localparam logic [4:0] ALU_OP_ADC = 5'd2;
  localparam logic [4:0] ALU_OP_SBB = 5'd3;
  localparam logic [4:0] ALU_OP_AND = 5'd4;
  localparam logic [4:0] ALU_OP_SUB = 5'd5;
  localparam logic [4:0] ALU_OP_XOR = 5'd6;
  localparam logic [4:0] ALU_OP_CMP = 5'd7;

  // x86 PF: set when the byte holds an even number of ones
  function automatic logic even_parity(input logic [7:0] value);
    return ~^value;
  endfunction

endpackage

// File: rtl/kfx86_alu_adder.sv
// Byte/word add-subtract with carry-in, producing x86-style carry, aux-carry and overflow.
module kfx86_alu_adder
  import kfx86_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  input  logic        subtract,
  input  logic        select_word,
  output logic [15:0] sum,
  output logic        carry,
  output logic        aux_carry,
  output logic        overflow
);

  logic [15:0] b_eff;
  logic        cin_eff;
  logic [16:0] sum_word;
  logic [8:0]  sum_byte;
  logic        raw_carry;
  logic        msb_a;
  logic        msb_b;
  logic        msb_r;

  // Subtraction is a + ~b + ~borrow_in; the final carry is inverted back into a borrow
  always_comb begin
    b_eff    = subtract ? ~b : b;
    cin_eff  = carry_in ^ subtract;
    sum_word = {1'b0, a} + {1'b0, b_eff} + {16'd0, cin_eff};
    sum_byte = {1'b0, a[7:0]} + {1'b0, b_eff[7:0]} + {8'd0, cin_eff};
    if (select_word) begin
      sum       = sum_word[15:0];
      raw_carry = sum_word[16];
      msb_a     = a[15];
      msb_b     = b_eff[15];
      msb_r     = sum_word[15];
    end else begin
      sum       = {8'h00, sum_byte[7:0]};
      raw_carry = sum_byte[8];
      msb_a     = a[7];
      msb_b     = b_eff[7];
      msb_r     = sum_byte[7];
    end
    carry     = raw_carry ^ subtract;
    aux_carry = a[4] ^ b[4] ^ sum[4];
    overflow  = (msb_a == msb_b) && (msb_r != msb_a);
  end

endmodule

// File: rtl/kfx86_alu_accumulator.sv
// KFX86 integer ALU: eight arithmetic/logic ops on byte or word operands with registered result and FLAGS.
module kfx86_alu_accumulator
  import kfx86_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [4:0]  opcode,
  input  logic [15:0] source_1,
  input  logic [15:0] source_2,
  input  logic [15:0] source_flags,
  input  logic        select_word,
  output logic [15:0] out,
  output logic [15:0] out_flags
);

  flags_t      in_flags;
  flags_t      nxt_flags;
  logic [15:0] nxt_out;
  logic [15:0] byte_mask;
  logic        valid_op;
  logic        subtract;
  logic        carry_in;
  logic [15:0] add_sum;
  logic        add_carry;
  logic        add_aux;
  logic        add_overflow;

  assign in_flags = flags_t'(source_flags);

  always_comb begin
    subtract = (opcode == ALU_OP_SUB) || (opcode == ALU_OP_SBB) || (opcode == ALU_OP_CMP);
    carry_in = ((opcode == ALU_OP_ADC) || (opcode == ALU_OP_SBB)) && in_flags.c;
  end

  kfx86_alu_adder u_adder (
    .a           (source_1),
    .b           (source_2),
    .carry_in    (carry_in),
    .subtract    (subtract),
    .select_word (select_word),
    .sum         (add_sum),
    .carry       (add_carry),
    .aux_carry   (add_aux),
    .overflow    (add_overflow)
  );

  always_comb begin
    nxt_out   = source_1;
    nxt_flags = in_flags;
    valid_op  = 1'b1;
    byte_mask = select_word ? 16'hFFFF : 16'h00FF;
    case (opcode)
      ALU_OP_ADD, ALU_OP_ADC, ALU_OP_SUB, ALU_OP_SBB, ALU_OP_CMP: begin
        nxt_out     = add_sum;
        nxt_flags.c = add_carry;
        nxt_flags.a = add_aux;
        nxt_flags.o = add_overflow;
      end
      ALU_OP_OR, ALU_OP_AND, ALU_OP_XOR: begin
        if (opcode == ALU_OP_OR)
          nxt_out = (source_1 | source_2) & byte_mask;
        else if (opcode == ALU_OP_AND)
          nxt_out = (source_1 & source_2) & byte_mask;
        else
          nxt_out = (source_1 ^ source_2) & byte_mask;
        nxt_flags.c = 1'b0;
        nxt_flags.a = 1'b0;
        nxt_flags.o = 1'b0;
      end
      default: valid_op = 1'b0;
    endcase
    // Byte results already have a zero high byte, so a full-width zero test is exact
    if (valid_op) begin
      nxt_flags.s = select_word ? nxt_out[15] : nxt_out[7];
      nxt_flags.z = (nxt_out == 16'h0000);
      nxt_flags.p = even_parity(nxt_out[7:0]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out       <= 16'h0000;
      out_flags <= 16'h0000;
    end else begin
      out       <= nxt_out;
      out_flags <= nxt_flags;
    end
  end

endmodule

// File: tb/tb_kfx86_alu_accumulator.sv
// Directed self-checking bench for kfx86_alu_accumulator with hand-computed results and flags.
module tb_kfx86_alu_accumulator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [4:0]  opcode;
  logic [15:0] source_1;
  logic [15:0] source_2;
  logic [15:0] source_flags;
  logic        select_word;
  logic [15:0] out;
  logic [15:0] out_flags;

  int total = 0;
  int bad   = 0;

  kfx86_alu_accumulator dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .source_1     (source_1),
    .source_2     (source_2),
    .source_flags (source_flags),
    .select_word  (select_word),
    .out          (out),
    .out_flags    (out_flags)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] op, input logic [15:0] s1, input logic [15:0] s2,
                                input logic [15:0] sf, input logic sw);
    @(negedge clock);
    opcode       = op;
    source_1     = s1;
    source_2     = s2;
    source_flags = sf;
    select_word  = sw;
  endtask

  task automatic run_vector(input string tag, input logic [4:0] op, input logic [15:0] s1,
                            input logic [15:0] s2, input logic [15:0] sf, input logic sw,
                            input logic [15:0] exp_out, input logic [15:0] exp_flags);
    apply_stimulus(op, s1, s2, sf, sw);
    @(posedge clock);
    #1;
    check_output({tag, "_out"}, out, exp_out);
    check_output({tag, "_flags"}, out_flags, exp_flags);
  endtask

  initial begin
    reset_n      = 1'b0;
    opcode       = 5'd0;
    source_1     = 16'h1111;
    source_2     = 16'h2222;
    source_flags = 16'hFFFF;
    select_word  = 1'b1;
    #3;
    check_output("reset_out", out, 16'h0000);
    check_output("reset_flags", out_flags, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;

    run_vector("add_w_8000",   5'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 16'h0000, 16'h0845);
    run_vector("adc_w_ffff",   5'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'h0095);
    run_vector("sub_b_0m1",    5'd5, 16'h0000, 16'h0001, 16'h0000, 1'b0, 16'h00FF, 16'h0095);
    run_vector("cmp_w_7fff",   5'd7, 16'h7FFF, 16'h8000, 16'h0000, 1'b1, 16'hFFFF, 16'h0885);
    run_vector("sbb_b_80",     5'd3, 16'h0080, 16'h0000, 16'h0001, 1'b0, 16'h007F, 16'h0810);
    run_vector("xor_w_passthr",5'd6, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b1, 16'hFFFF, 16'hF7AE);
    run_vector("add_b_hi_ign", 5'd0, 16'h12FF, 16'h3401, 16'h0000, 1'b0, 16'h0000, 16'h0055);
    run_vector("add_w_no_cf",  5'd0, 16'h0001, 16'h0001, 16'h0001, 1'b1, 16'h0002, 16'h0000);
    run_vector("and_w_clr_co", 5'd4, 16'hF0F0, 16'h0FF0, 16'h0801, 1'b1, 16'h00F0, 16'h0004);
    run_vector("or_b_80",      5'd1, 16'h1200, 16'h0080, 16'h0000, 1'b0, 16'h0080, 16'h0080);
    run_vector("bad_opcode",   5'd31, 16'hBEEF, 16'h0F0F, 16'h1234, 1'b0, 16'hBEEF, 16'h1234);

    // One-cycle latency: new operands must not show until the next rising edge
    apply_stimulus(5'd0, 16'h0003, 16'h0004, 16'h0000, 1'b1);
    #1;
    check_output("latency_hold", out, 16'hBEEF);
    @(posedge clock);
    #1;
    check_output("latency_out", out, 16'h0007);
    check_output("latency_flags", out_flags, 16'h0000);

    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_rst_out", out, 16'h0000);
    check_output("async_rst_flags", out_flags, 16'h0000);
    @(posedge clock);
    #1;
    check_output("rst_hold_out", out, 16'h0000);

    apply_stimulus(5'd5, 16'h0010, 16'h0001, 16'h0000, 1'b1);
    reset_n = 1'b1;
    #1;
    check_output("rel_no_edge", out, 16'h0000);
    @(posedge clock);
    #1;
    check_output("rel_cap_out", out, 16'h000F);
    check_output("rel_cap_flags", out_flags, 16'h0014);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
